// File: rtl/weight_load_seq_if.sv
// Weight stream and filter-FIFO write bundle for weight_load_seq.
// The sequencer takes the slave side; the stream source / FIFO bank take master.
interface weight_load_seq_if #(
  parameter int MAX_FILTERS = 32,
  parameter int DATA_W      = 16
);
  logic [2*DATA_W-1:0]    s_data_i;
  logic                   s_valid_i;
  logic                   s_ready_o;
  logic [MAX_FILTERS-1:0] fifo_full_i;
  logic [MAX_FILTERS-1:0] weight_en_o;
  logic [2*DATA_W-1:0]    wdata_o;
  logic [1:0]             lane_vld_o;

  modport slave (
    input  s_data_i, s_valid_i, fifo_full_i,
    output s_ready_o, weight_en_o, wdata_o, lane_vld_o
  );

  modport master (
    output s_data_i, s_valid_i, fifo_full_i,
    input  s_ready_o, weight_en_o, wdata_o, lane_vld_o
  );
endinterface

// File: rtl/weight_load_seq.sv
// Steers 2-element weight beats into per-filter FIFOs, filter by filter.
// Each filter starts on a fresh beat; an odd tail writes lane0 only.
module weight_load_seq #(
  parameter int MAX_FILTERS = 32,
  parameter int DATA_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [5:0] num_filt_i,
  input  logic [4:0] num_elem_i,
  input  logic       abort_i,
  weight_load_seq_if.slave wl,
  output logic       busy_o,
  output logic       done_o,
  output logic       cfg_err_o
);
  localparam int FW = (MAX_FILTERS > 1) ? $clog2(MAX_FILTERS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                 state_q, state_d;
  logic [FW-1:0]          filt_idx_q, filt_idx_d;
  logic [4:0]             elem_cnt_q, elem_cnt_d;
  logic [5:0]             nf_q, nf_d;
  logic [4:0]             ne_q, ne_d;
  logic [MAX_FILTERS-1:0] weight_en_q, weight_en_d;
  logic [2*DATA_W-1:0]    wdata_q, wdata_d;
  logic [1:0]             lane_vld_q, lane_vld_d;
  logic                   cfg_err_q, cfg_err_d;

  logic s_ready;
  logic accept;
  logic last_beat;
  logic last_filt;
  logic cfg_ok;

  assign cfg_ok = (num_filt_i != 6'd0)
                && ({1'b0, num_filt_i} <= 7'(MAX_FILTERS))
                && (num_elem_i != 5'd0);

  assign s_ready = (state_q == LOAD)
                 && !wl.fifo_full_i[filt_idx_q]
                 && !abort_i;
  assign accept  = s_ready && wl.s_valid_i;

  assign last_beat = ({1'b0, elem_cnt_q} + 6'd2)
                   >= {1'b0, ne_q};
  assign last_filt = 6'(filt_idx_q) == (nf_q - 6'd1);

  always_comb begin
    state_d     = state_q;
    filt_idx_d  = filt_idx_q;
    elem_cnt_d  = elem_cnt_q;
    nf_d        = nf_q;
    ne_d        = ne_q;
    weight_en_d = '0;
    wdata_d     = wdata_q;
    lane_vld_d  = 2'b00;
    cfg_err_d   = 1'b0;

    // Write side lags acceptance by one cycle.
    if (accept) begin
      weight_en_d = {{(MAX_FILTERS-1){1'b0}}, 1'b1} << filt_idx_q;
      wdata_d     = wl.s_data_i;
      lane_vld_d  = (last_beat && ne_q[0]) ? 2'b01 : 2'b11;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            nf_d       = num_filt_i;
            ne_d       = num_elem_i;
            filt_idx_d = '0;
            elem_cnt_d = '0;
            state_d    = LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d    = IDLE;
          filt_idx_d = '0;
          elem_cnt_d = '0;
        end else if (accept) begin
          if (last_beat) begin
            elem_cnt_d = '0;
            if (last_filt) state_d = DONE;
            else filt_idx_d = filt_idx_q + 1'b1;
          end else begin
            elem_cnt_d = elem_cnt_q + 5'd2;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        filt_idx_d = '0;
        elem_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      filt_idx_q  <= '0;
      elem_cnt_q  <= '0;
      nf_q        <= '0;
      ne_q        <= '0;
      weight_en_q <= '0;
      wdata_q     <= '0;
      lane_vld_q  <= 2'b00;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_idx_q  <= filt_idx_d;
      elem_cnt_q  <= elem_cnt_d;
      nf_q        <= nf_d;
      ne_q        <= ne_d;
      weight_en_q <= weight_en_d;
      wdata_q     <= wdata_d;
      lane_vld_q  <= lane_vld_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign wl.s_ready_o   = s_ready;
  assign wl.weight_en_o = weight_en_q;
  assign wl.wdata_o     = wdata_q;
  assign wl.lane_vld_o  = lane_vld_q;
  assign busy_o         = state_q != IDLE;
  // An abort landing on the DONE cycle suppresses the completion pulse.
  assign done_o         = (state_q == DONE) && !abort_i;
  assign cfg_err_o      = cfg_err_q;
endmodule
